// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: FSM encoding, frame command
// bytes, the timeout error byte and the ALU function codes.
package alu_cmd_sequencer_pkg;

  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] ERR_BYTE    = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_A    = 4'd1,
    ST_GET_B    = 4'd2,
    ST_GET_FUN  = 4'd3,
    ST_GATE_ON  = 4'd4,
    ST_RUN      = 4'd5,
    ST_WAIT_RES = 4'd6,
    ST_SEND_LO  = 4'd7,
    ST_SEND_HI  = 4'd8
  } seq_state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_MUL   = 4'h2,
    ALU_DIV   = 4'h3,
    ALU_AND   = 4'h4,
    ALU_OR    = 4'h5,
    ALU_NAND  = 4'h6,
    ALU_NOR   = 4'h7,
    ALU_XOR   = 4'h8,
    ALU_XNOR  = 4'h9,
    ALU_CMPEQ = 4'hA,
    ALU_CMPGT = 4'hB,
    ALU_CMPLT = 4'hC,
    ALU_SHR   = 4'hD,
    ALU_SHL   = 4'hE
  } alu_fun_e;

  // ALU clock gate is open from gate setup until the result arrives.
  function automatic logic gate_state(input seq_state_e st);
    logic on_s;
    case (st)
      ST_GATE_ON, ST_RUN, ST_WAIT_RES: on_s = 1'b1;
      default:                         on_s = 1'b0;
    endcase
    return on_s;
  endfunction

  function automatic logic rx_blocked_state(input seq_state_e st);
    logic blk_s;
    case (st)
      ST_GATE_ON, ST_RUN, ST_WAIT_RES, ST_SEND_LO, ST_SEND_HI: blk_s = 1'b1;
      default:                                                  blk_s = 1'b0;
    endcase
    return blk_s;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the sequencer and its RX stream, ALU and TX path.
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   Rx_data;
  logic                    Rx_valid;
  logic [2*DATA_WIDTH-1:0] ALU_out;
  logic                    ALU_valid;
  logic                    Tx_ready;
  logic [DATA_WIDTH-1:0]   ALU_A;
  logic [DATA_WIDTH-1:0]   ALU_B;
  logic [3:0]              ALU_FUN;
  logic                    ALU_EN;
  logic                    Gate_EN;
  logic [DATA_WIDTH-1:0]   Tx_data;
  logic                    Tx_valid;
  logic                    Busy;
  logic                    Err_cmd;
  logic                    Overrun;

  modport master (
    input  Rx_data, Rx_valid, ALU_out, ALU_valid, Tx_ready,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, Gate_EN, Tx_data, Tx_valid,
           Busy, Err_cmd, Overrun
  );

  modport slave (
    output Rx_data, Rx_valid, ALU_out, ALU_valid, Tx_ready,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, Gate_EN, Tx_data, Tx_valid,
           Busy, Err_cmd, Overrun
  );
endinterface

// File: rtl/alu_cmd_sequencer_timeout.sv
// Loadable down-counter bounding the wait for the ALU result; expire flags the
// last allowed wait cycle.
module alu_seq_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_r;

  // Counter: load on entry to the wait, count down while waiting.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= CNT_W'(TIMEOUT);
    end else if (en && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = en && (count_r == CNT_W'(1));
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Frame-level ALU controller: parses RX command frames, drives the ALU with a
// gated clock and returns the result (or an error byte) over the TX handshake.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input logic                 CLK,
  input logic                 Reset,
  alu_cmd_sequencer_if.master bus
);
  import alu_cmd_sequencer_pkg::*;

  localparam int RW = 2 * DATA_WIDTH;

  seq_state_e            state_r, state_nxt_s;
  logic [RW-1:0]         result_r, result_nxt_s;
  logic                  err_r, err_nxt_s;
  logic [DATA_WIDTH-1:0] a_r, a_nxt_s, b_r, b_nxt_s;
  logic [3:0]            fun_r, fun_nxt_s;
  logic                  err_cmd_r, err_cmd_nxt_s;
  logic                  overrun_r, overrun_nxt_s;
  logic                  alu_en_r, alu_en_nxt_s;
  logic                  gate_r, gate_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  tx_valid_r, tx_valid_nxt_s;
  logic [DATA_WIDTH-1:0] tx_data_r, tx_data_nxt_s;
  logic                  tmo_load_s, tmo_en_s, tmo_expire_s;

  alu_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK    (CLK),
    .Reset  (Reset),
    .load   (tmo_load_s),
    .en     (tmo_en_s),
    .expire (tmo_expire_s)
  );

  // Next-state, datapath and look-ahead output decode.
  always_comb begin
    state_nxt_s   = state_r;
    result_nxt_s  = result_r;
    err_nxt_s     = err_r;
    a_nxt_s       = a_r;
    b_nxt_s       = b_r;
    fun_nxt_s     = fun_r;
    err_cmd_nxt_s = 1'b0;
    tmo_load_s    = 1'b0;
    tmo_en_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.Rx_valid) begin
          if (bus.Rx_data == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_nxt_s = ST_GET_A;
          end else if (bus.Rx_data == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_nxt_s = ST_GET_FUN;
          end else begin
            err_cmd_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GET_A: begin
        if (bus.Rx_valid) begin
          a_nxt_s     = bus.Rx_data;
          state_nxt_s = ST_GET_B;
        end else begin
          state_nxt_s = ST_GET_A;
        end
      end
      ST_GET_B: begin
        if (bus.Rx_valid) begin
          b_nxt_s     = bus.Rx_data;
          state_nxt_s = ST_GET_FUN;
        end else begin
          state_nxt_s = ST_GET_B;
        end
      end
      ST_GET_FUN: begin
        if (bus.Rx_valid) begin
          fun_nxt_s   = bus.Rx_data[3:0];
          state_nxt_s = ST_GATE_ON;
        end else begin
          state_nxt_s = ST_GET_FUN;
        end
      end
      ST_GATE_ON: state_nxt_s = ST_RUN;
      ST_RUN: begin
        tmo_load_s  = 1'b1;
        err_nxt_s   = 1'b0;
        state_nxt_s = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        tmo_en_s = 1'b1;
        // A result arriving on the expiry cycle is still taken.
        if (bus.ALU_valid) begin
          result_nxt_s = bus.ALU_out;
          state_nxt_s  = ST_SEND_LO;
        end else if (tmo_expire_s) begin
          result_nxt_s = {{DATA_WIDTH{1'b0}}, DATA_WIDTH'(ERR_BYTE)};
          err_nxt_s    = 1'b1;
          state_nxt_s  = ST_SEND_LO;
        end else begin
          state_nxt_s = ST_WAIT_RES;
        end
      end
      ST_SEND_LO: begin
        if (bus.Tx_ready) begin
          state_nxt_s = err_r ? ST_IDLE : ST_SEND_HI;
        end else begin
          state_nxt_s = ST_SEND_LO;
        end
      end
      ST_SEND_HI: begin
        if (bus.Tx_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND_HI;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    gate_nxt_s     = gate_state(state_nxt_s);
    alu_en_nxt_s   = (state_nxt_s == ST_RUN);
    busy_nxt_s     = (state_nxt_s != ST_IDLE);
    overrun_nxt_s  = bus.Rx_valid && rx_blocked_state(state_r);
    tx_valid_nxt_s = 1'b0;
    tx_data_nxt_s  = {DATA_WIDTH{1'b0}};
    case (state_nxt_s)
      ST_SEND_LO: begin
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = result_nxt_s[DATA_WIDTH-1:0];
      end
      ST_SEND_HI: begin
        tx_valid_nxt_s = 1'b1;
        tx_data_nxt_s  = result_nxt_s[RW-1:DATA_WIDTH];
      end
      default: begin
        tx_valid_nxt_s = 1'b0;
        tx_data_nxt_s  = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State, operand/result registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      result_r   <= {RW{1'b0}};
      err_r      <= 1'b0;
      a_r        <= {DATA_WIDTH{1'b0}};
      b_r        <= {DATA_WIDTH{1'b0}};
      fun_r      <= 4'h0;
      err_cmd_r  <= 1'b0;
      overrun_r  <= 1'b0;
      alu_en_r   <= 1'b0;
      gate_r     <= 1'b0;
      busy_r     <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      result_r   <= result_nxt_s;
      err_r      <= err_nxt_s;
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      fun_r      <= fun_nxt_s;
      err_cmd_r  <= err_cmd_nxt_s;
      overrun_r  <= overrun_nxt_s;
      alu_en_r   <= alu_en_nxt_s;
      gate_r     <= gate_nxt_s;
      busy_r     <= busy_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
    end
  end

  assign bus.ALU_A    = a_r;
  assign bus.ALU_B    = b_r;
  assign bus.ALU_FUN  = fun_r;
  assign bus.ALU_EN   = alu_en_r;
  assign bus.Gate_EN  = gate_r;
  assign bus.Tx_data  = tx_data_r;
  assign bus.Tx_valid = tx_valid_r;
  assign bus.Busy     = busy_r;
  assign bus.Err_cmd  = err_cmd_r;
  assign bus.Overrun  = overrun_r;
endmodule
